// File: rtl/somador_pkg.sv
// ============================================================================
// Module      : somador_pkg
// Description : Shared types and constants for the round-robin adder scheduler.
// Revision    : 1.0
// ============================================================================
`default_nettype none

package somador_pkg;

    localparam int DEF_WIDTH = 4;
    localparam int STAT_W    = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        HOLD = 2'd2
    } state_t;

endpackage

`default_nettype wire

// File: rtl/rr_prioridade.sv
// ============================================================================
// Module      : rr_prioridade
// Description : Combinational round-robin picker, highest priority at ptr.
// Revision    : 1.0
// ============================================================================
`default_nettype none

module rr_prioridade #(
    parameter int N_REQ = 2,
    parameter int ID_W  = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
    input  logic [N_REQ-1:0] req,
    input  logic [ID_W-1:0]  ptr,
    output logic [N_REQ-1:0] gnt,
    output logic [ID_W-1:0]  gnt_idx,
    output logic             any
);

    // Scan from the farthest position back to ptr so the closest valid one wins.
    always_comb begin
        gnt     = '0;
        gnt_idx = '0;
        any     = 1'b0;
        for (int k = N_REQ - 1; k >= 0; k--) begin
            int idx;
            idx = int'(ptr) + k;
            if (idx >= N_REQ) begin
                idx = idx - N_REQ;
            end
            if (req[idx]) begin
                gnt      = '0;
                gnt[idx] = 1'b1;
                gnt_idx  = ID_W'(idx);
                any      = 1'b1;
            end
        end
    end

endmodule

`default_nettype wire

// File: rtl/somador_arbitro_rr.sv
// ============================================================================
// Module      : somador_arbitro_rr
// Description : Round-robin scheduler sharing one 4-bit adder-mux among
//               N_REQ requesters. Optional SOMARB_STATS_EN adds grant counters.
// Revision    : 1.0
// ============================================================================
`default_nettype none

module somador_arbitro_rr
    import somador_pkg::*;
#(
    parameter int N_REQ = 2,
    parameter int WIDTH = DEF_WIDTH,
    parameter int ID_W  = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [N_REQ-1:0]       req_valid,
    output logic [N_REQ-1:0]       req_ready,
    input  logic [N_REQ*WIDTH-1:0] req_a,
    input  logic [N_REQ*WIDTH-1:0] req_b,
    input  logic [N_REQ*WIDTH-1:0] req_c,
    input  logic [N_REQ-1:0]       req_sel,
    output logic [WIDTH-1:0]       ia,
    output logic [WIDTH-1:0]       ib,
    output logic [WIDTH-1:0]       ic,
    output logic                   select,
    input  logic [WIDTH-1:0]       out_som,
    output logic                   resp_valid,
    input  logic                   resp_ready,
    output logic [WIDTH-1:0]       resp_data,
    output logic [ID_W-1:0]        resp_id
`ifdef SOMARB_STATS_EN
   ,output logic [N_REQ*STAT_W-1:0] grant_cnt
`endif
);

    state_t           state;
    state_t           state_nxt;
    logic [ID_W-1:0]  ptr;
    logic [N_REQ-1:0] gnt;
    logic [ID_W-1:0]  gnt_idx;
    logic             gnt_any;
    logic             hs;
    logic [WIDTH-1:0] sel_a;
    logic [WIDTH-1:0] sel_b;
    logic [WIDTH-1:0] sel_c;
    logic             sel_s;

    rr_prioridade #(
        .N_REQ (N_REQ),
        .ID_W  (ID_W)
    ) u_prio (
        .req     (req_valid),
        .ptr     (ptr),
        .gnt     (gnt),
        .gnt_idx (gnt_idx),
        .any     (gnt_any)
    );

    assign hs = (state == IDLE) && gnt_any;

    always_comb begin
        sel_a = '0;
        sel_b = '0;
        sel_c = '0;
        sel_s = 1'b0;
        for (int i = 0; i < N_REQ; i++) begin
            if (gnt_idx == ID_W'(i)) begin
                sel_a = req_a[i*WIDTH +: WIDTH];
                sel_b = req_b[i*WIDTH +: WIDTH];
                sel_c = req_c[i*WIDTH +: WIDTH];
                sel_s = req_sel[i];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (gnt_any) state_nxt = EXEC;
            EXEC:    state_nxt = HOLD;
            HOLD:    if (resp_ready) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        req_ready = '0;
        if (state == IDLE) begin
            req_ready = gnt;
        end
    end

    // Adder operand registers keep their last values between transactions.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ia         <= '0;
            ib         <= '0;
            ic         <= '0;
            select     <= 1'b0;
            resp_valid <= 1'b0;
            resp_data  <= '0;
            resp_id    <= '0;
            ptr        <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (hs) begin
                        ia      <= sel_a;
                        ib      <= sel_b;
                        ic      <= sel_c;
                        select  <= sel_s;
                        resp_id <= gnt_idx;
                    end
                end
                EXEC: begin
                    resp_data  <= out_som;
                    resp_valid <= 1'b1;
                end
                HOLD: begin
                    if (resp_ready) begin
                        resp_valid <= 1'b0;
                        ptr        <= (resp_id == ID_W'(N_REQ - 1)) ? '0 : resp_id + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

`ifdef SOMARB_STATS_EN
    generate
        for (genvar g = 0; g < N_REQ; g++) begin : g_stats
            logic [STAT_W-1:0] cnt;
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    cnt <= '0;
                end else if (hs && gnt[g] && (cnt != {STAT_W{1'b1}})) begin
                    cnt <= cnt + 1'b1;
                end
            end
            assign grant_cnt[g*STAT_W +: STAT_W] = cnt;
        end
    endgenerate
`endif

endmodule

`default_nettype wire

// File: tb/tb_somador_arbitro_rr.sv
// ============================================================================
// Module      : tb_somador_arbitro_rr
// Description : Directed self-checking bench for somador_arbitro_rr with a
//               behavioural model of the shared adder-mux.
// Revision    : 1.0
// ============================================================================
`default_nettype none

module tb_somador_arbitro_rr;

    localparam int N_REQ = 2;
    localparam int WIDTH = 4;
    localparam int ID_W  = 1;

    logic                   clk = 1'b0;
    logic                   rst_n = 1'b0;
    logic [N_REQ-1:0]       req_valid = '0;
    logic [N_REQ-1:0]       req_ready;
    logic [N_REQ*WIDTH-1:0] req_a = '0;
    logic [N_REQ*WIDTH-1:0] req_b = '0;
    logic [N_REQ*WIDTH-1:0] req_c = '0;
    logic [N_REQ-1:0]       req_sel = '0;
    logic [WIDTH-1:0]       ia, ib, ic;
    logic                   select;
    logic [WIDTH-1:0]       out_som;
    logic                   resp_valid;
    logic                   resp_ready = 1'b0;
    logic [WIDTH-1:0]       resp_data;
    logic [ID_W-1:0]        resp_id;
`ifdef SOMARB_STATS_EN
    logic [N_REQ*8-1:0]     grant_cnt;
`endif

    int vectors = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    assign out_som = ia + (select ? ic : ib);

    somador_arbitro_rr #(
        .N_REQ (N_REQ),
        .WIDTH (WIDTH),
        .ID_W  (ID_W)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_a      (req_a),
        .req_b      (req_b),
        .req_c      (req_c),
        .req_sel    (req_sel),
        .ia         (ia),
        .ib         (ib),
        .ic         (ic),
        .select     (select),
        .out_som    (out_som),
        .resp_valid (resp_valid),
        .resp_ready (resp_ready),
        .resp_data  (resp_data),
        .resp_id    (resp_id)
`ifdef SOMARB_STATS_EN
       ,.grant_cnt  (grant_cnt)
`endif
    );

    task automatic load(input int i, input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                        input logic [WIDTH-1:0] c, input logic s);
        req_a[i*WIDTH +: WIDTH] = a;
        req_b[i*WIDTH +: WIDTH] = b;
        req_c[i*WIDTH +: WIDTH] = c;
        req_sel[i]              = s;
        req_valid[i]            = 1'b1;
    endtask

    task automatic reset_dut();
        req_valid  = '0;
        resp_ready = 1'b0;
        rst_n      = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        vectors++;
        if ({resp_valid, resp_data, resp_id, req_ready, ia, ib, ic, select} !== '0) begin
            miscompares++;
            $display("FAIL reset_outputs: got valid=%b data=%0d id=%0d rdy=%b ia=%0d ib=%0d ic=%0d sel=%b, need all 0",
                     resp_valid, resp_data, resp_id, req_ready, ia, ib, ic, select);
        end
        #1 rst_n = 1'b1;
    endtask

    task automatic test_single();
        @(posedge clk); #1 load(0, 4'd3, 4'd5, 4'd1, 1'b0);
        @(negedge clk);
        vectors++;
        if (req_ready !== 2'b01) begin
            miscompares++;
            $display("FAIL single_ready: got %b need 01", req_ready);
        end
        @(posedge clk); #1 req_valid = '0;
        vectors++;
        if (req_ready !== 2'b00 || ia !== 4'd3 || ib !== 4'd5 || ic !== 4'd1 || select !== 1'b0) begin
            miscompares++;
            $display("FAIL single_exec: got rdy=%b ia=%0d ib=%0d ic=%0d sel=%b need 00/3/5/1/0",
                     req_ready, ia, ib, ic, select);
        end
        @(posedge clk); #1;
        vectors++;
        if (resp_valid !== 1'b1 || resp_data !== 4'd8 || resp_id !== 1'b0) begin
            miscompares++;
            $display("FAIL single_resp: got v=%b d=%0d id=%0d need 1/8/0", resp_valid, resp_data, resp_id);
        end
        resp_ready = 1'b1;
        @(posedge clk); #1 resp_ready = 1'b0;
        vectors++;
        if (resp_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL single_done: got resp_valid=%b need 0", resp_valid);
        end
    endtask

    task automatic test_select();
        load(1, 4'd7, 4'd0, 4'd2, 1'b1);
        @(negedge clk);
        vectors++;
        if (req_ready !== 2'b10) begin
            miscompares++;
            $display("FAIL select_ready: got %b need 10", req_ready);
        end
        @(posedge clk); #1 req_valid = '0;
        @(posedge clk); #1;
        vectors++;
        if (resp_valid !== 1'b1 || resp_data !== 4'd9 || resp_id !== 1'b1) begin
            miscompares++;
            $display("FAIL select_resp: got v=%b d=%0d id=%0d need 1/9/1", resp_valid, resp_data, resp_id);
        end
        resp_ready = 1'b1;
        @(posedge clk); #1 resp_ready = 1'b0;
    endtask

    task automatic test_contention();
        reset_dut();
        load(0, 4'd3, 4'd5, 4'd1, 1'b0);
        load(1, 4'd1, 4'd2, 4'd0, 1'b0);
        resp_ready = 1'b1;
        for (int t = 0; t < 4; t++) begin
            bit got;
            got = 1'b0;
            for (int k = 0; k < 10 && !got; k++) begin
                @(negedge clk);
                if (resp_valid === 1'b1) got = 1'b1;
            end
            if (t == 3) req_valid = '0;
            vectors++;
            if (!got) begin
                miscompares++;
                $display("FAIL contention_timeout: txn %0d got no resp_valid need one", t);
            end else if (resp_id !== ID_W'(t % 2) || resp_data !== ((t % 2) ? 4'd3 : 4'd8)) begin
                miscompares++;
                $display("FAIL contention_txn%0d: got id=%0d d=%0d need id=%0d d=%0d",
                         t, resp_id, resp_data, t % 2, (t % 2) ? 3 : 8);
            end
        end
        @(posedge clk); #1 resp_ready = 1'b0;
    endtask

    task automatic test_back_pressure();
        load(0, 4'd4, 4'd2, 4'd0, 1'b0);
        @(negedge clk);
        vectors++;
        if (req_ready !== 2'b01) begin
            miscompares++;
            $display("FAIL bp_ready: got %b need 01", req_ready);
        end
        @(posedge clk); #1 load(1, 4'd1, 4'd1, 4'd1, 1'b0);
        @(posedge clk);
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            vectors++;
            if (resp_valid !== 1'b1 || resp_data !== 4'd6 || resp_id !== 1'b0 || req_ready !== 2'b00) begin
                miscompares++;
                $display("FAIL bp_hold%0d: got v=%b d=%0d id=%0d rdy=%b need 1/6/0/00",
                         k, resp_valid, resp_data, resp_id, req_ready);
            end
        end
        req_valid  = '0;
        resp_ready = 1'b1;
        @(posedge clk); #1 resp_ready = 1'b0;
        vectors++;
        if (resp_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL bp_release: got resp_valid=%b need 0", resp_valid);
        end
    endtask

    task automatic test_wrap();
        int          ids[2]  = '{1, 0};
        logic [3:0]  av[2]   = '{4'd9, 4'd15};
        logic [3:0]  bv[2]   = '{4'd9, 4'd0};
        logic [3:0]  cv[2]   = '{4'd0, 4'd15};
        logic        sv[2]   = '{1'b0, 1'b1};
        logic [3:0]  ev[2]   = '{4'd2, 4'd14};
        for (int t = 0; t < 2; t++) begin
            load(ids[t], av[t], bv[t], cv[t], sv[t]);
            @(posedge clk); #1 req_valid = '0;
            @(posedge clk); #1;
            vectors++;
            if (resp_valid !== 1'b1 || resp_data !== ev[t] || resp_id !== ID_W'(ids[t])) begin
                miscompares++;
                $display("FAIL wrap%0d: got v=%b d=%0d id=%0d need 1/%0d/%0d",
                         t, resp_valid, resp_data, resp_id, ev[t], ids[t]);
            end
            resp_ready = 1'b1;
            @(posedge clk); #1 resp_ready = 1'b0;
        end
    endtask

    task automatic test_reset_mid();
        load(1, 4'd5, 4'd5, 4'd5, 1'b1);
        @(posedge clk); #1 req_valid = '0;
        #1 rst_n = 1'b0;
        #1;
        vectors++;
        if (resp_valid !== 1'b0 || {ia, ib, ic, select} !== '0 || req_ready !== 2'b00) begin
            miscompares++;
            $display("FAIL midreset_clear: got v=%b ia=%0d ib=%0d ic=%0d sel=%b rdy=%b need all 0",
                     resp_valid, ia, ib, ic, select, req_ready);
        end
        @(posedge clk); #1 rst_n = 1'b1;
        resp_ready = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        vectors++;
        if (resp_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL midreset_noresp: got resp_valid=%b need 0", resp_valid);
        end
        resp_ready = 1'b0;
        load(0, 4'd0, 4'd0, 4'd0, 1'b0);
        load(1, 4'd0, 4'd0, 4'd0, 1'b0);
        #1;
        vectors++;
        if (req_ready !== 2'b01) begin
            miscompares++;
            $display("FAIL midreset_ptr: got req_ready=%b need 01", req_ready);
        end
        reset_dut();
    endtask

`ifdef SOMARB_STATS_EN
    task automatic test_stats();
        reset_dut();
        @(negedge clk);
        vectors++;
        if (grant_cnt !== 16'h0000) begin
            miscompares++;
            $display("FAIL stats_reset: got %h need 0000", grant_cnt);
        end
        load(0, 4'd1, 4'd1, 4'd1, 1'b0);
        resp_ready = 1'b1;
        repeat (910) @(posedge clk);
        #1 req_valid = '0;
        repeat (5) @(posedge clk);
        @(negedge clk);
        vectors++;
        if (grant_cnt[7:0] !== 8'd255 || grant_cnt[15:8] !== 8'd0) begin
            miscompares++;
            $display("FAIL stats_saturate: got cnt0=%0d cnt1=%0d need 255/0", grant_cnt[7:0], grant_cnt[15:8]);
        end
        resp_ready = 1'b0;
    endtask
`endif

    initial begin
        test_reset();
        test_single();
        test_select();
        test_contention();
        test_back_pressure();
        test_wrap();
        test_reset_mid();
`ifdef SOMARB_STATS_EN
        test_stats();
`endif
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

`default_nettype wire
